bp_be_mmu_cmd_tracker: RTL and testbench



---
 rtl/bp_be_mmu_cmd_tracker_pkg.sv | 43 ++++
 rtl/bp_be_mmu_cmd_tracker_if.sv | 43 ++++
 rtl/bp_be_mmu_cmd_tracker_mem.sv | 24 ++
 rtl/bp_be_mmu_cmd_tracker.sv | 116 +++++++++++
 tb/tb_bp_be_mmu_cmd_tracker.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_mmu_cmd_tracker_pkg.sv
// Shared types for the BE-to-MMU in-order command tracker: command and response
// payloads, the logical tracker entry, and default widths.
package bp_be_mmu_cmd_tracker_pkg;

    localparam int rv64_eaddr_width_gp      = 64;
    localparam int rv64_reg_data_width_gp   = 64;
    localparam int bp_be_itag_width_gp      = 8;
    localparam int bp_be_mmu_tracker_els_gp = 4;

    typedef enum logic [3:0] {
        e_op_lb, e_op_lh, e_op_lw, e_op_ld, e_op_lbu, e_op_lhu, e_op_lwu,
        e_op_sb, e_op_sh, e_op_sw, e_op_sd
    } bp_be_fu_op_e;

    typedef struct packed {
        bp_be_fu_op_e                      fu_op;
        logic [rv64_eaddr_width_gp-1:0]    vaddr;
        logic [rv64_reg_data_width_gp-1:0] data;
    } bp_be_mmu_cmd_s;

    typedef struct packed {
        logic misaligned;
        logic access_fault;
        logic page_fault;
    } bp_be_mmu_exc_s;

    typedef struct packed {
        logic [rv64_reg_data_width_gp-1:0] data;
        bp_be_mmu_exc_s                    exc;
    } bp_be_mmu_resp_s;

    // Logical view of one slot; the tracker splits it across a 1r1w payload memory and flop arrays.
    typedef struct packed {
        bp_be_mmu_cmd_s                   cmd;
        logic [bp_be_itag_width_gp-1:0]   itag;
        logic                             poison;
    } bp_be_mmu_tracker_entry_s;

    localparam int bp_be_mmu_cmd_width           = $bits(bp_be_mmu_cmd_s);
    localparam int bp_be_mmu_resp_width          = $bits(bp_be_mmu_resp_s);
    localparam int bp_be_mmu_tracker_entry_width = $bits(bp_be_mmu_tracker_entry_s);

endpackage

// File: rtl/bp_be_mmu_cmd_tracker_if.sv
// Pipeline-side and MMU-side signals of the command tracker, bundled as one interface.
interface bp_be_mmu_cmd_tracker_if
    import bp_be_mmu_cmd_tracker_pkg::*;
#(
    parameter int itag_width_p = bp_be_itag_width_gp
) ();

    logic                    cmd_v_i;
    bp_be_mmu_cmd_s          cmd_i;
    logic [itag_width_p-1:0] cmd_itag_i;
    logic                    cmd_ready_o;

    logic                    mmu_cmd_v_o;
    bp_be_mmu_cmd_s          mmu_cmd_o;
    logic                    mmu_cmd_ready_i;

    logic                    mmu_resp_v_i;
    bp_be_mmu_resp_s         mmu_resp_i;
    logic                    mmu_resp_ready_o;

    logic                    resp_v_o;
    bp_be_mmu_resp_s         resp_o;
    logic [itag_width_p-1:0] resp_itag_o;
    logic                    resp_ready_i;

    logic                    flush_i;
    logic                    empty_o;

    modport slave (
        input  cmd_v_i, cmd_i, cmd_itag_i, mmu_cmd_ready_i, mmu_resp_v_i, mmu_resp_i,
               resp_ready_i, flush_i,
        output cmd_ready_o, mmu_cmd_v_o, mmu_cmd_o, mmu_resp_ready_o, resp_v_o, resp_o,
               resp_itag_o, empty_o
    );

    modport master (
        output cmd_v_i, cmd_i, cmd_itag_i, mmu_cmd_ready_i, mmu_resp_v_i, mmu_resp_i,
               resp_ready_i, flush_i,
        input  cmd_ready_o, mmu_cmd_v_o, mmu_cmd_o, mmu_resp_ready_o, resp_v_o, resp_o,
               resp_itag_o, empty_o
    );

endinterface

// File: rtl/bp_be_mmu_cmd_tracker_mem.sv
// 1-write/1-read register-file storage for command payloads (bsg_mem_1r1w role):
// synchronous write, asynchronous read.
module bp_be_mmu_cmd_tracker_mem #(
    parameter int els_p   = 4,
    parameter int width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // NOTE: storage is deliberately not reset; slot validity lives only in the tracker pointers.
    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_mmu_cmd_tracker.sv
// In-order MMU command tracker: alloc/issue/retire pointers over a circular buffer,
// itag pairing of in-order responses, and flush by poisoning issued slots.
module bp_be_mmu_cmd_tracker
    import bp_be_mmu_cmd_tracker_pkg::*;
#(
    parameter int els_p        = bp_be_mmu_tracker_els_gp,
    parameter int itag_width_p = bp_be_itag_width_gp
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_be_mmu_cmd_tracker_if.slave io
);

    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;

    typedef logic [ptr_w-1:0] ptr_t;
    typedef logic [idx_w-1:0] idx_t;

    ptr_t wptr_r, iptr_r, rptr_r;
    ptr_t wptr_n, iptr_n, rptr_n;
    ptr_t live_n;
    idx_t widx, iidx, ridx;

    logic [itag_width_p-1:0]        itag_r [els_p];
    logic [els_p-1:0]               poison_r, poison_n;
    logic [bp_be_mmu_cmd_width-1:0] mmu_cmd_raw;

    logic full, enq, issue_v, issue, retire_v, retire;

    assign widx = wptr_r[idx_w-1:0];
    assign iidx = iptr_r[idx_w-1:0];
    assign ridx = rptr_r[idx_w-1:0];

    assign full           = (wptr_r - rptr_r) == ptr_t'(els_p);
    assign io.cmd_ready_o = ~full & ~reset_i;
    assign enq            = io.cmd_v_i & io.cmd_ready_o & ~io.flush_i;

    assign issue_v        = iptr_r != wptr_r;
    assign issue          = issue_v & io.mmu_cmd_ready_i;
    assign io.mmu_cmd_v_o = issue_v;
    assign io.mmu_cmd_o   = bp_be_mmu_cmd_s'(mmu_cmd_raw);

    bp_be_mmu_cmd_tracker_mem #(
        .els_p  (els_p),
        .width_p(bp_be_mmu_cmd_width)
    ) cmd_mem (
        .clk_i   (clk_i),
        .w_v_i   (enq),
        .w_addr_i(widx),
        .w_data_i(io.cmd_i),
        .r_addr_i(iidx),
        .r_data_o(mmu_cmd_raw)
    );

    assign retire_v = rptr_r != iptr_r;

    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave one unassigned (no latch).
        io.resp_v_o         = 1'b0;
        io.mmu_resp_ready_o = 1'b0;
        if (retire_v) begin
            if (poison_r[ridx]) begin
                io.mmu_resp_ready_o = 1'b1;
            end else begin
                io.resp_v_o         = io.mmu_resp_v_i;
                io.mmu_resp_ready_o = io.resp_ready_i;
            end
        end
    end

    assign io.resp_o      = io.mmu_resp_i;
    assign io.resp_itag_o = itag_r[ridx];
    assign retire         = io.mmu_resp_v_i & io.mmu_resp_ready_o;
    assign io.empty_o     = wptr_r == rptr_r;

    // Flush rewinds alloc to the post-issue pointer, so same-cycle issues survive as poisoned slots.
    assign iptr_n = iptr_r + ptr_t'(issue);
    assign rptr_n = rptr_r + ptr_t'(retire);
    assign wptr_n = io.flush_i ? iptr_n : wptr_r + ptr_t'(enq);
    assign live_n = iptr_n - rptr_n;

    always_comb begin
        poison_n = poison_r;
        if (enq) poison_n[widx] = 1'b0;
        for (int i = 0; i < els_p; i++) begin
            idx_t off;
            off = idx_t'(i) - rptr_n[idx_w-1:0];
            if (io.flush_i && (ptr_t'(off) < live_n)) poison_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset_i) begin
            wptr_r   <= '0;
            iptr_r   <= '0;
            rptr_r   <= '0;
            poison_r <= '0;
        end else begin
            wptr_r   <= wptr_n;
            iptr_r   <= iptr_n;
            rptr_r   <= rptr_n;
            poison_r <= poison_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) itag_r[widx] <= io.cmd_itag_i;
    end

    // The MMU must never answer more commands than it has been issued.
    resp_in_order: assert property (@(posedge clk_i) disable iff (reset_i)
        io.mmu_resp_v_i |-> retire_v);

endmodule

// File: tb/tb_bp_be_mmu_cmd_tracker.sv
// Self-checking bench for bp_be_mmu_cmd_tracker: directed scenarios plus randomized
// traffic scored against a queue-based model of pending and outstanding commands.
module tb_bp_be_mmu_cmd_tracker;
    import bp_be_mmu_cmd_tracker_pkg::*;

    localparam int ELS = 4;
    localparam logic [63:0] RESP_KEY = 64'h5a5a_0f0f_3c3c_a5a5;

    typedef logic [bp_be_itag_width_gp-1:0] itag_t;

    typedef struct packed {
        itag_t          itag;
        bp_be_mmu_cmd_s cmd;
        logic           killed;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bp_be_mmu_cmd_tracker_if #(.itag_width_p(bp_be_itag_width_gp)) io ();

    bp_be_mmu_cmd_tracker #(
        .els_p       (ELS),
        .itag_width_p(bp_be_itag_width_gp)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .io     (io.slave)
    );

    ent_t        pend_q[$];
    ent_t        out_q[$];
    logic [63:0] iss_log[$];
    itag_t       resp_log[$];
    int          resp_cyc[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;

    task automatic set_in(input logic cv, input itag_t tag, input logic [63:0] addr,
                          input logic mrdy, input logic mrv, input logic rrdy, input logic fl);
        io.cmd_v_i    = cv;
        io.cmd_itag_i = tag;
        io.cmd_i      = '{fu_op: bp_be_fu_op_e'(4'($urandom_range(0, 10))), vaddr: addr,
                          data: {$urandom, $urandom}};
        io.mmu_cmd_ready_i = mrdy;
        io.mmu_resp_v_i    = mrv && (out_q.size() != 0);
        io.mmu_resp_i.data = '0;
        if (out_q.size() != 0) io.mmu_resp_i.data = out_q[0].cmd.data ^ RESP_KEY;
        io.mmu_resp_i.exc  = bp_be_mmu_exc_s'(3'($urandom));
        io.resp_ready_i    = rrdy;
        io.flush_i         = fl;
    endtask

    task automatic compare_to_model(input string tn);
        logic e_rdy, e_cv, e_rv, e_rr, e_empty;
        e_rdy   = (pend_q.size() + out_q.size()) < ELS;
        e_cv    = pend_q.size() != 0;
        e_empty = (pend_q.size() + out_q.size()) == 0;
        e_rv    = 1'b0;
        e_rr    = 1'b0;
        if (out_q.size() != 0) begin
            if (out_q[0].killed) e_rr = 1'b1;
            else begin
                e_rv = io.mmu_resp_v_i;
                e_rr = io.resp_ready_i;
            end
        end
        n_total++;
        if (io.cmd_ready_o !== e_rdy) $display("FAIL %s cmd_ready got %b exp %b", tn, io.cmd_ready_o, e_rdy);
        else n_pass++;
        n_total++;
        if (io.mmu_cmd_v_o !== e_cv) $display("FAIL %s mmu_cmd_v got %b exp %b", tn, io.mmu_cmd_v_o, e_cv);
        else n_pass++;
        if (e_cv) begin
            n_total++;
            if (io.mmu_cmd_o !== pend_q[0].cmd)
                $display("FAIL %s mmu_cmd got %h exp %h", tn, io.mmu_cmd_o, pend_q[0].cmd);
            else n_pass++;
        end
        n_total++;
        if (io.mmu_resp_ready_o !== e_rr) $display("FAIL %s mmu_resp_ready got %b exp %b", tn, io.mmu_resp_ready_o, e_rr);
        else n_pass++;
        n_total++;
        if (io.resp_v_o !== e_rv) $display("FAIL %s resp_v got %b exp %b", tn, io.resp_v_o, e_rv);
        else n_pass++;
        if (e_rv) begin
            n_total++;
            if (io.resp_itag_o !== out_q[0].itag)
                $display("FAIL %s resp_itag got %0d exp %0d", tn, io.resp_itag_o, out_q[0].itag);
            else n_pass++;
            n_total++;
            if (io.resp_o !== io.mmu_resp_i) $display("FAIL %s resp got %h exp %h", tn, io.resp_o, io.mmu_resp_i);
            else n_pass++;
        end
        n_total++;
        if (io.empty_o !== e_empty) $display("FAIL %s empty got %b exp %b", tn, io.empty_o, e_empty);
        else n_pass++;
    endtask

    task automatic at_neg(input string tn);
        @(negedge clk);
        if (!reset) compare_to_model(tn);
        if (io.mmu_cmd_v_o === 1'b1 && io.mmu_cmd_ready_i) iss_log.push_back(io.mmu_cmd_o.vaddr);
        if (io.resp_v_o === 1'b1 && io.resp_ready_i) begin
            resp_log.push_back(io.resp_itag_o);
            resp_cyc.push_back(cyc);
        end
    endtask

    task automatic at_pos();
        int   cnt;
        logic do_iss, do_ret, do_enq;
        ent_t e;
        @(posedge clk);
        if (reset) begin
            pend_q.delete();
            out_q.delete();
        end else begin
            cnt    = pend_q.size() + out_q.size();
            do_iss = (pend_q.size() != 0) && io.mmu_cmd_ready_i;
            do_ret = (out_q.size() != 0) && io.mmu_resp_v_i && (out_q[0].killed || io.resp_ready_i);
            do_enq = io.cmd_v_i && (cnt < ELS) && !io.flush_i;
            e      = '{itag: io.cmd_itag_i, cmd: io.cmd_i, killed: 1'b0};
            if (do_ret) void'(out_q.pop_front());
            if (do_iss) out_q.push_back(pend_q.pop_front());
            if (io.flush_i) begin
                foreach (out_q[i]) out_q[i].killed = 1'b1;
                pend_q.delete();
            end else if (do_enq) begin
                pend_q.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step(input string tn);
        at_neg(tn);
        at_pos();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset");
        at_neg("reset");
        n_total++; if (io.cmd_ready_o !== 1'b0) $display("FAIL reset_cmd_ready got %b exp 0", io.cmd_ready_o); else n_pass++;
        n_total++; if (io.mmu_cmd_v_o !== 1'b0) $display("FAIL reset_mmu_cmd_v got %b exp 0", io.mmu_cmd_v_o); else n_pass++;
        n_total++; if (io.resp_v_o !== 1'b0) $display("FAIL reset_resp_v got %b exp 0", io.resp_v_o); else n_pass++;
        n_total++; if (io.mmu_resp_ready_o !== 1'b0) $display("FAIL reset_mmu_resp_ready got %b exp 0", io.mmu_resp_ready_o); else n_pass++;
        n_total++; if (io.empty_o !== 1'b1) $display("FAIL reset_empty got %b exp 1", io.empty_o); else n_pass++;
        at_pos();
        reset = 1'b0;
        at_neg("reset_exit");
        n_total++; if (io.cmd_ready_o !== 1'b1) $display("FAIL reset_exit_ready got %b exp 1", io.cmd_ready_o); else n_pass++;
        at_pos();
    endtask

    task automatic test_single();
        set_in(1'b1, itag_t'(5), 64'h8000_0124, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg("single_enq");
        n_total++; if (io.mmu_cmd_v_o !== 1'b0) $display("FAIL single_bypass mmu_cmd_v got %b exp 0", io.mmu_cmd_v_o); else n_pass++;
        at_pos();
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        at_neg("single_issue");
        n_total++; if (io.mmu_cmd_v_o !== 1'b1) $display("FAIL single_issue_v got %b exp 1", io.mmu_cmd_v_o); else n_pass++;
        n_total++; if (io.mmu_cmd_o.vaddr !== 64'h8000_0124) $display("FAIL single_issue_addr got %h exp 80000124", io.mmu_cmd_o.vaddr); else n_pass++;
        at_pos();
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        io.mmu_resp_i.data = 64'hdead;
        at_neg("single_resp");
        n_total++; if (io.resp_v_o !== 1'b1) $display("FAIL single_resp_v got %b exp 1", io.resp_v_o); else n_pass++;
        n_total++; if (io.resp_itag_o !== itag_t'(5)) $display("FAIL single_resp_itag got %0d exp 5", io.resp_itag_o); else n_pass++;
        n_total++; if (io.resp_o.data !== 64'hdead) $display("FAIL single_resp_data got %h exp dead", io.resp_o.data); else n_pass++;
        at_pos();
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg("single_done");
        n_total++; if (io.empty_o !== 1'b1) $display("FAIL single_empty got %b exp 1", io.empty_o); else n_pass++;
        at_pos();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            set_in(1'b1, itag_t'(i), 64'(i * 16), 1'b0, 1'b0, 1'b1, 1'b0);
            at_neg("fill");
            if (i == 5) begin
                n_total++; if (io.cmd_ready_o !== 1'b0) $display("FAIL fill_full_ready got %b exp 0", io.cmd_ready_o); else n_pass++;
            end
            at_pos();
        end
        iss_log.delete();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
            step("fill_issue");
        end
        n_total++; if (iss_log.size() != 4) $display("FAIL fill_issue_count got %0d exp 4", iss_log.size()); else n_pass++;
        foreach (iss_log[i]) begin
            n_total++;
            if (iss_log[i] !== 64'((i + 1) * 16)) $display("FAIL fill_issue_order got %h exp %h", iss_log[i], 64'((i + 1) * 16));
            else n_pass++;
        end
        resp_log.delete();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            step("fill_resp");
        end
        n_total++; if (resp_log.size() != 4) $display("FAIL fill_resp_count got %0d exp 4", resp_log.size()); else n_pass++;
        foreach (resp_log[i]) begin
            n_total++;
            if (resp_log[i] !== itag_t'(i + 1)) $display("FAIL fill_resp_itag got %0d exp %0d", resp_log[i], i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int base;
        resp_log.delete();
        resp_cyc.delete();
        base = cyc;
        for (int k = 0; k < 12; k++) begin
            set_in(k < 10, itag_t'(k), 64'h1000 + 64'(k), 1'b1, 1'b1, 1'b1, 1'b0);
            step("wrap");
        end
        n_total++; if (resp_log.size() != 10) $display("FAIL wrap_count got %0d exp 10", resp_log.size()); else n_pass++;
        foreach (resp_log[i]) begin
            n_total++;
            if (resp_log[i] !== itag_t'(i) || resp_cyc[i] - base != i + 2)
                $display("FAIL wrap_resp got itag %0d cyc %0d exp itag %0d cyc %0d", resp_log[i], resp_cyc[i] - base, i, i + 2);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, itag_t'(10 + k), 64'h2000 + 64'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            step("flush_fill");
        end
        for (int k = 0; k < 2; k++) begin
            set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
            step("flush_issue");
        end
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("flush");
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg("flush_after");
        n_total++; if (io.mmu_cmd_v_o !== 1'b0) $display("FAIL flush_cmd_v got %b exp 0", io.mmu_cmd_v_o); else n_pass++;
        n_total++; if (io.empty_o !== 1'b0) $display("FAIL flush_not_empty got %b exp 0", io.empty_o); else n_pass++;
        at_pos();
        for (int k = 0; k < 2; k++) begin
            set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            at_neg("flush_drop");
            n_total++; if (io.mmu_resp_ready_o !== 1'b1) $display("FAIL flush_drop_ready got %b exp 1", io.mmu_resp_ready_o); else n_pass++;
            n_total++; if (io.resp_v_o !== 1'b0) $display("FAIL flush_drop_resp_v got %b exp 0", io.resp_v_o); else n_pass++;
            at_pos();
        end
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg("flush_drained");
        n_total++; if (io.empty_o !== 1'b1) $display("FAIL flush_empty got %b exp 1", io.empty_o); else n_pass++;
        at_pos();
    endtask

    task automatic test_flush_collision();
        set_in(1'b1, itag_t'(20), 64'h3000, 1'b0, 1'b0, 1'b1, 1'b0);
        step("coll_a");
        set_in(1'b1, itag_t'(21), 64'h3001, 1'b1, 1'b0, 1'b1, 1'b0);
        step("coll_b");
        set_in(1'b1, itag_t'(22), 64'h3002, 1'b1, 1'b1, 1'b1, 1'b1);
        at_neg("coll_flush");
        n_total++; if (io.resp_v_o !== 1'b1) $display("FAIL coll_retire_v got %b exp 1", io.resp_v_o); else n_pass++;
        n_total++; if (io.resp_itag_o !== itag_t'(20)) $display("FAIL coll_retire_itag got %0d exp 20", io.resp_itag_o); else n_pass++;
        at_pos();
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        at_neg("coll_after");
        n_total++; if (io.mmu_cmd_v_o !== 1'b0) $display("FAIL coll_enq_dropped got %b exp 0", io.mmu_cmd_v_o); else n_pass++;
        n_total++; if (io.empty_o !== 1'b0) $display("FAIL coll_poisoned_live got %b exp 0", io.empty_o); else n_pass++;
        at_pos();
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        at_neg("coll_drop");
        n_total++; if (io.resp_v_o !== 1'b0) $display("FAIL coll_drop_v got %b exp 0", io.resp_v_o); else n_pass++;
        n_total++; if (io.mmu_resp_ready_o !== 1'b1) $display("FAIL coll_drop_ready got %b exp 1", io.mmu_resp_ready_o); else n_pass++;
        at_pos();
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg("coll_done");
        n_total++; if (io.empty_o !== 1'b1) $display("FAIL coll_empty got %b exp 1", io.empty_o); else n_pass++;
        at_pos();
    endtask

    task automatic test_backpressure();
        set_in(1'b1, itag_t'(30), 64'h4000, 1'b0, 1'b0, 1'b1, 1'b0);
        step("bp_enq");
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("bp_issue");
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            at_neg("bp_hold");
            n_total++; if (io.mmu_resp_ready_o !== 1'b0) $display("FAIL bp_hold_ready got %b exp 0", io.mmu_resp_ready_o); else n_pass++;
            n_total++; if (io.resp_itag_o !== itag_t'(30)) $display("FAIL bp_hold_itag got %0d exp 30", io.resp_itag_o); else n_pass++;
            at_pos();
        end
        set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        at_neg("bp_release");
        n_total++; if (io.resp_v_o !== 1'b1 || io.mmu_resp_ready_o !== 1'b1)
            $display("FAIL bp_release got v %b rdy %b exp 1 1", io.resp_v_o, io.mmu_resp_ready_o);
        else n_pass++;
        at_pos();
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg("bp_done");
        n_total++; if (io.empty_o !== 1'b1) $display("FAIL bp_empty got %b exp 1", io.empty_o); else n_pass++;
        at_pos();
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            if (k == 250) reset = 1'b1;
            if (k == 252) reset = 1'b0;
            set_in($urandom_range(0, 3) != 0, itag_t'($urandom), {$urandom, $urandom},
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            step("random");
        end
        for (int k = 0; k < 20; k++) begin
            set_in(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
            step("random_drain");
        end
        at_neg("random_end");
        n_total++; if (io.empty_o !== 1'b1) $display("FAIL random_final_empty got %b exp 1", io.empty_o); else n_pass++;
        at_pos();
    endtask

    initial begin
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_flush_collision();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
